// File: rtl/dense_input_feeder_if.sv
// Handshake and output bundle for the dense-layer input feeder.
// The upstream word port and the dense-layer port are grouped in one interface.
interface dense_input_feeder_if #(
  parameter int IN_WIDTH   = 16,
  parameter int INPUT_SIZE = 4,
  parameter int NUM_CYC    = 512
);
  localparam int BW = $clog2(NUM_CYC);

  logic                  in_vld;
  logic                  in_rdy;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  vld_out;
  logic [INPUT_SIZE-1:0] data_out;
  logic [BW-1:0]         w_addr;
  logic                  busy;

  modport master (
    output in_vld, in_data,
    input  in_rdy, vld_out, data_out, w_addr, busy
  );

  modport slave (
    input  in_vld, in_data,
    output in_rdy, vld_out, data_out, w_addr, busy
  );
endinterface

// File: rtl/dense_input_feeder.sv
// Ping-pong frame buffer: fills one bank from upstream words while the
// other bank streams INPUT_SIZE-bit chunks to the binary dense layer.
module dense_input_feeder #(
  parameter int IN_WIDTH   = 16,
  parameter int INPUT_SIZE = 4,
  parameter int NUM_CYC    = 512
) (
  input  logic clk,
  input  logic rst,
  dense_input_feeder_if.slave bus
);
  localparam int FRAME_BITS = NUM_CYC * INPUT_SIZE;
  localparam int WORDS      = FRAME_BITS / IN_WIDTH;
  localparam int BW         = $clog2(NUM_CYC);
  localparam int WW         = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int FW         = $clog2(FRAME_BITS);
  localparam logic [WW-1:0] W_LAST = WW'(WORDS - 1);
  localparam logic [BW-1:0] C_LAST = BW'(NUM_CYC - 1);

  typedef enum logic {IDLE, STREAM} state_e;

  logic [FRAME_BITS-1:0] bank_q [2];

  state_e                state_q, state_d;
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic [WW-1:0]         wcnt_q, wcnt_d;
  logic                  rd_bank_q, rd_bank_d;
  logic [BW-1:0]         ccnt_q, ccnt_d;
  logic                  vld_q, vld_d;
  logic                  busy_q, busy_d;
  logic [INPUT_SIZE-1:0] data_q, data_d;

  logic                  in_rdy;
  logic                  wr_fire;
  logic [FW-1:0]         wbase;
  logic [FW-1:0]         rbase;

  assign in_rdy       = !full_q[wr_bank_q];
  assign wr_fire      = bus.in_vld & in_rdy;
  assign wbase        = FW'(int'(wcnt_q) * IN_WIDTH);
  assign bus.in_rdy   = in_rdy;
  assign bus.vld_out  = vld_q;
  assign bus.busy     = busy_q;
  assign bus.data_out = data_q;
  assign bus.w_addr   = ccnt_q;

  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wcnt_d    = wcnt_q;
    rd_bank_d = rd_bank_q;
    ccnt_d    = ccnt_q;
    vld_d     = 1'b0;
    busy_d    = 1'b0;
    data_d    = '0;
    rbase     = '0;

    if (wr_fire) begin
      if (wcnt_q == W_LAST) begin
        wcnt_d            = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wcnt_d = wcnt_q + WW'(1);
      end
    end

    // A write never targets the bank being cleared, so both updates coexist.
    unique case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d = STREAM;
          ccnt_d  = '0;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      STREAM: begin
        busy_d = 1'b1;
        if (ccnt_q == C_LAST) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          ccnt_d            = '0;
          if (full_q[~rd_bank_q]) begin
            vld_d = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          ccnt_d = ccnt_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (busy_d) begin
      rbase  = FW'(int'(ccnt_d) * INPUT_SIZE);
      data_d = bank_q[rd_bank_d][rbase +: INPUT_SIZE];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wcnt_q    <= '0;
      rd_bank_q <= 1'b0;
      ccnt_q    <= '0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wcnt_q    <= wcnt_d;
      rd_bank_q <= rd_bank_d;
      ccnt_q    <= ccnt_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      data_q    <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      bank_q[wr_bank_q][wbase +: IN_WIDTH] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_dense_input_feeder.sv
// Directed and randomized bench for the ping-pong dense input feeder.
// Expected chunks are sliced from whole frames assembled from the sent words.
module tb_dense_input_feeder;
  localparam int IW = 16;
  localparam int IS = 4;
  localparam int NC = 8;
  localparam int WORDS = NC * IS / IW;

  typedef struct packed {
    int         cyc;
    logic       v;
    logic [2:0] a;
    logic [3:0] d;
  } ob_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  dense_input_feeder_if #(.IN_WIDTH(IW), .INPUT_SIZE(IS), .NUM_CYC(NC)) bus ();

  dense_input_feeder #(
    .IN_WIDTH(IW), .INPUT_SIZE(IS), .NUM_CYC(NC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ob_t         obs[$];
  logic [31:0] exp_q[$];
  logic [15:0] cur_words[$];
  int          total = 0;
  int          passed = 0;
  int          hs_cyc;

  always @(negedge clk) begin
    if (rst && (bus.busy || bus.vld_out))
      obs.push_back('{cyc, bus.vld_out, bus.w_addr, bus.data_out});
  end

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    logic ok;
    logic hs;
    logic [31:0] f;
    int c;
    bus.in_vld = 1'b0;
    tick(gap);
    bus.in_vld  = 1'b1;
    bus.in_data = w;
    ok = 1'b0;
    c = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      hs = bus.in_rdy;
      c  = cyc;
      @(posedge clk);
      #1;
      if (hs) ok = 1'b1;
    end
    bus.in_vld  = 1'b0;
    bus.in_data = 16'($urandom);
    hs_cyc = c;
    if (!ok) check("handshake_timeout", ok, 1);
    else begin
      cur_words.push_back(w);
      if (cur_words.size() == WORDS) begin
        f = '0;
        for (int k = 0; k < WORDS; k++)
          f = f | (32'(cur_words[k]) << (IW * k));
        exp_q.push_back(f);
        cur_words.delete();
      end
    end
  endtask

  task automatic check_stream(input string tag);
    int n;
    int j;
    logic [31:0] f;
    logic [7:0] e;
    logic [7:0] o;
    n = exp_q.size() * NC;
    check({tag, "_len"}, obs.size(), n);
    for (int i = 0; i < obs.size() && i < n; i++) begin
      j = i % NC;
      f = exp_q[i / NC];
      e = {(j == 0), 3'(j), 4'((f >> (IS * j)) & 32'hF)};
      o = {obs[i].v, obs[i].a, obs[i].d};
      check($sformatf("%s_chunk%0d", tag, i), o, e);
      if (j > 0)
        check($sformatf("%s_gap%0d", tag, i), obs[i].cyc - obs[i-j].cyc, j);
    end
    obs.delete();
    exp_q.delete();
  endtask

  function automatic int first_cyc();
    return (obs.size() > 0) ? obs[0].cyc : -1;
  endfunction

  initial begin
    int hs[6];
    int c;
    logic found;

    bus.in_vld  = 1'b0;
    bus.in_data = '0;
    rst = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("rst_in_rdy", bus.in_rdy, 1);
    check("rst_vld", bus.vld_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_data", bus.data_out, 0);
    check("rst_addr", bus.w_addr, 0);

    // single frame, fixed words
    send_word(16'h3210, 0);
    send_word(16'h7654, 0);
    c = hs_cyc;
    tick(15);
    check("single_lat", first_cyc(), c + 2);
    check_stream("single");

    // back-to-back: six words with valid held high
    for (int w = 0; w < 6; w++) begin
      send_word(16'($urandom), 0);
      hs[w] = hs_cyc;
      if (w == 3) check("b2b_rdy_low", bus.in_rdy, 0);
    end
    tick(30);
    check("b2b_fill", hs[3] - hs[0], 3);
    check("b2b_rdy_rise", hs[4], first_cyc() + NC);
    check_stream("b2b");

    // random upstream gaps
    for (int w = 0; w < 6; w++)
      send_word(16'($urandom), $urandom_range(0, 3));
    tick(40);
    check_stream("gaps");

    // reset in the middle of a frame with a second frame buffered
    for (int w = 0; w < 4; w++)
      send_word(16'($urandom), 0);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      @(negedge clk);
      if (bus.busy && bus.w_addr == 3'd3) found = 1'b1;
    end
    check("mid_reach_chunk3", found, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_vld", bus.vld_out, 0);
    check("mid_busy", bus.busy, 0);
    check("mid_data", bus.data_out, 0);
    check("mid_addr", bus.w_addr, 0);
    check("mid_in_rdy", bus.in_rdy, 1);
    obs.delete();
    exp_q.delete();
    cur_words.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    tick(30);
    check("mid_quiet", obs.size(), 0);
    send_word(16'($urandom), 0);
    send_word(16'($urandom), 0);
    c = hs_cyc;
    tick(15);
    check("mid_lat", first_cyc(), c + 2);
    check_stream("mid");

    // partial frame is held until completed
    send_word(16'($urandom), 0);
    tick(100);
    check("partial_hold", obs.size(), 0);
    send_word(16'($urandom), 2);
    c = hs_cyc;
    tick(15);
    check("partial_lat", first_cyc(), c + 2);
    check_stream("partial");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dense_input_feeder.md
# dense_input_feeder

Ping-pong frame buffer and sequencer that sits directly upstream of the binary dense layer. It accepts the flattened binary activation vector as IN_WIDTH-bit words over a valid/ready handshake and stores a complete frame of NUM_CYC*INPUT_SIZE bits. It then streams the frame to the dense layer as INPUT_SIZE bits per cycle for NUM_CYC consecutive cycles, with a start pulse and a weight-ROM address. Two banks allow the next frame to be filled while the current one streams.

## Interface
- IN_WIDTH, 16, upstream word width; must be a multiple of INPUT_SIZE and divide NUM_CYC*INPUT_SIZE.
- INPUT_SIZE, 4, bits per cycle presented to the dense layer.
- NUM_CYC, 512, chunks per frame; power of two.
- Derived: FRAME_BITS = NUM_CYC*INPUT_SIZE; WORDS = FRAME_BITS/IN_WIDTH; BW = $clog2(NUM_CYC); WW = max(1,$clog2(WORDS)).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_vld  in  1  upstream word valid.
- in_rdy  out  1  feeder can accept a word.
- in_data  in  IN_WIDTH  activation word; word k holds frame bits [k*IN_WIDTH +: IN_WIDTH].
- vld_out  out  1  one-cycle pulse coincident with chunk 0 of each frame; drives the dense layer vld_in.
- data_out  out  INPUT_SIZE  current chunk; drives the dense layer data_in.
- w_addr  out  BW  chunk index of data_out; addresses the weight ROM.
- busy  out  1  high on every cycle that data_out carries a valid chunk.

## Operation
- Storage: two banks of FRAME_BITS bits, bank[0] and bank[1], each with a full flag. The write pointer is wr_bank plus word counter wcnt (WW bits). The read pointer is rd_bank plus chunk counter ccnt (BW bits).
- Write side: in_rdy = !full[wr_bank], combinational from registers only. On in_vld & in_rdy, in_data is stored at bank[wr_bank][wcnt*IN_WIDTH +: IN_WIDTH].
  - If wcnt == WORDS-1: wcnt returns to 0, full[wr_bank] is set and wr_bank toggles.
  - Otherwise wcnt increments.
  - in_data is ignored whenever the handshake does not occur.
- Read FSM, two states:
  - IDLE: busy=0, vld_out=0. If full[rd_bank], go to STREAM, register ccnt=0, vld_out=1, busy=1, data_out=chunk 0.
  - STREAM: data_out = bank[rd_bank][ccnt*INPUT_SIZE +: INPUT_SIZE], w_addr = ccnt, busy=1. vld_out=1 only when ccnt==0.
  - STREAM at ccnt == NUM_CYC-1: clear full[rd_bank] and toggle rd_bank. If the other bank is full, continue in STREAM with ccnt=0 and vld_out=1, so frames are back-to-back with no gap. Otherwise go to IDLE.
- Chunk order: chunk j = frame bits [j*INPUT_SIZE +: INPUT_SIZE], j ascending from 0. The LSB of in_data word 0 is bit 0 of chunk 0.
- Simultaneous set and clear: a write cannot target a full bank. A clear at the last chunk and a set completing the other bank in the same cycle are independent and both take effect.
- Never more than two frames are buffered; the upstream stalls via in_rdy.
- A partial frame (wcnt != 0) is held indefinitely until completed.

## Timing
- Reset (rst low, asynchronous): in_rdy=1 after release, vld_out=0, busy=0, data_out=0, w_addr=0. Both full flags, wcnt, ccnt, wr_bank and rd_bank are set to 0; the FSM goes to IDLE.
- Reset mid-stream aborts the frame immediately; both buffered frames and any partial frame are discarded. Bank contents need no reset.
- Latency: the final word of a frame is accepted in cycle c. vld_out/chunk 0 appear in cycle c+2 if the FSM was IDLE. The last chunk appears in cycle c+1+NUM_CYC.
- in_rdy for a freed bank rises in the cycle after its last chunk is presented.
- The dense layer requires NUM_CYC contiguous chunks after vld_out and accepts a new vld_out the cycle after the last chunk. The feeder guarantees both conditions.
- data_out, w_addr, vld_out and busy are all registered outputs.

## Test plan
(IN_WIDTH=16, INPUT_SIZE=4, NUM_CYC=8, so WORDS=2.)
- Reset values: hold rst low -> in_rdy=1 after release, vld_out=0, busy=0, data_out=0, w_addr=0.
- Single frame, words 0x3210 then 0x7654 -> vld_out pulses 2 cycles after the second handshake. data_out = 0,1,2,3,4,5,6,7 with w_addr 0..7 and busy high for exactly 8 cycles, then IDLE.
- Back-to-back: in_vld held high for 6 words (frames A, B, C) -> in_rdy drops after B is buffered. Output streams 24 contiguous busy cycles with vld_out at offsets 0, 8 and 16, in order A, B, C. in_rdy rises the cycle after A's last chunk.
- Upstream gaps: in_vld toggled randomly -> chunk sequence is identical to the gap-free case; no chunk is duplicated or dropped.
- Reset mid-stream: assert rst at chunk 3 with a second frame buffered -> outputs return to 0 asynchronously and nothing streams after release until two new words arrive.
- Partial frame: send one word only -> no vld_out for 100 cycles. Send the second word -> stream starts 2 cycles later.
